color_sensor_target: RTL and testbench

- I2C target (responder) that models the RGB light sensor at address 0x44 on the shared sda/scl bus.
- Answers the configuration writes and burst reads that the sensor-polling initiator issues.
- Lets the full initiator path be exercised on the board and in simulation without the physical sensor.
- Holds a 16-byte register file; the RGB data registers are loaded from a sample input port.

---
 rtl/color_sensor_target.sv | 235 +++++++++++++++++++++++
 tb/tb_color_sensor_target.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_sensor_target.sv
// I2C target that stands in for the RGB light sensor: 16-entry register map,
// pointer-based burst reads/writes, and tear-free commit of colour samples.
`timescale 1ns/1ps
module color_sensor_target #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h44,
    parameter logic [7:0] DEVICE_ID      = 8'h7D
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        scl_i,
    inout  wire         sda_io,
    input  logic [15:0] red_i,
    input  logic [15:0] green_i,
    input  logic [15:0] blue_i,
    input  logic        sample_valid_i,
    output logic [7:0]  config1_o,
    output logic [7:0]  config2_o,
    output logic [7:0]  config3_o,
    output logic        busy_o
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_sync_q, sda_sync_q;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        phase_q, phase_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic [7:0]  cfg1_q, cfg1_d, cfg2_q, cfg2_d, cfg3_q, cfg3_d;
    logic        status_q, status_d;
    logic [47:0] color_q, color_d;
    logic [47:0] pend_q, pend_d;
    logic        pend_valid_q, pend_valid_d;

    logic        sda_now, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]  shifted, rd_byte;
    logic [47:0] sample_word;

    // Stage [1] is the synchronized level, stage [2] the edge-detector history.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl_i};
            sda_sync_q <= {sda_sync_q[1:0], sda_io};
        end
    end

    assign sda_now     = sda_sync_q[1];
    assign scl_rise    = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall    = ~scl_sync_q[1] & scl_sync_q[2];
    assign start_det   = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
    assign stop_det    = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
    assign shifted     = {shift_q[6:0], sda_now};
    assign sample_word = {blue_i, red_i, green_i};

    always_comb begin
        rd_byte = 8'h00;
        case (ptr_q)
            4'h0:    rd_byte = DEVICE_ID;
            4'h1:    rd_byte = cfg1_q;
            4'h2:    rd_byte = cfg2_q;
            4'h3:    rd_byte = cfg3_q;
            4'h8:    rd_byte = {7'd0, status_q};
            4'h9:    rd_byte = color_q[7:0];
            4'hA:    rd_byte = color_q[15:8];
            4'hB:    rd_byte = color_q[23:16];
            4'hC:    rd_byte = color_q[31:24];
            4'hD:    rd_byte = color_q[39:32];
            4'hE:    rd_byte = color_q[47:40];
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ptr_d        = ptr_q;
        rw_d         = rw_q;
        phase_d      = phase_q;
        oe_d         = oe_q;
        busy_d       = busy_q;
        cfg1_d       = cfg1_q;
        cfg2_d       = cfg2_q;
        cfg3_d       = cfg3_q;
        status_d     = status_q;
        color_d      = color_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            phase_d   = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            phase_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            if (state_q == ADDR) begin
                                if (shifted[7:1] == DEVICE_ADDRESS) begin
                                    state_d = ADDR_ACK;
                                    rw_d    = shifted[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = IGNORE;
                                end
                            end else if (state_q == PTR) begin
                                ptr_d   = shifted[3:0];
                                state_d = PTR_ACK;
                            end else begin
                                case (ptr_q)
                                    4'h1:    cfg1_d = shifted;
                                    4'h2:    cfg2_d = shifted;
                                    4'h3:    cfg3_d = shifted;
                                    default: ;
                                endcase
                                ptr_d   = ptr_q + 4'd1;
                                state_d = WDATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK, RACK: begin
                    // phase 0: first fall after the byte; phase 1: fall that ends the ACK slot
                    if (state_q == RACK && scl_rise) begin
                        if (sda_now) state_d = IGNORE;
                        else         phase_d = 1'b1;
                    end else if (scl_fall && !phase_q) begin
                        oe_d = (state_q != RACK);
                        if (state_q != RACK) phase_d = 1'b1;
                    end else if (scl_fall) begin
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        oe_d      = 1'b0;
                        if (state_q == RACK || (state_q == ADDR_ACK && rw_q)) begin
                            shift_d = rd_byte;
                            oe_d    = ~rd_byte[7];
                            ptr_d   = ptr_q + 4'd1;
                            state_d = RDATA;
                            if (ptr_q == 4'h8) status_d = 1'b0;
                        end else begin
                            state_d = (state_q == ADDR_ACK) ? PTR : WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = RACK;
                            phase_d = 1'b0;
                        end
                    end else if (scl_fall) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                    end
                end
                default: ;
            endcase
        end

        // Samples arriving mid-transfer are parked so a burst read never sees a mix.
        if (sample_valid_i && !busy_q) begin
            color_d      = sample_word;
            status_d     = 1'b1;
            pend_valid_d = 1'b0;
        end else if (sample_valid_i) begin
            pend_d       = sample_word;
            pend_valid_d = 1'b1;
        end else if (pend_valid_q && !busy_q) begin
            color_d      = pend_q;
            status_d     = 1'b1;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            ptr_q        <= 4'h0;
            rw_q         <= 1'b0;
            phase_q      <= 1'b0;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            cfg1_q       <= 8'h00;
            cfg2_q       <= 8'h00;
            cfg3_q       <= 8'h00;
            status_q     <= 1'b0;
            color_q      <= 48'd0;
            pend_q       <= 48'd0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            rw_q         <= rw_d;
            phase_q      <= phase_d;
            oe_q         <= oe_d;
            busy_q       <= busy_d;
            cfg1_q       <= cfg1_d;
            cfg2_q       <= cfg2_d;
            cfg3_q       <= cfg3_d;
            status_q     <= status_d;
            color_q      <= color_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign sda_io    = oe_q ? 1'b0 : 1'bz;
    assign config1_o = cfg1_q;
    assign config2_o = cfg2_q;
    assign config3_o = cfg3_q;
    assign busy_o    = busy_q;
endmodule

// File: tb/tb_color_sensor_target.sv
// Bench for color_sensor_target: bit-banged I2C initiator with a queue of
// expected read bytes compared against what comes back off the bus.
`timescale 1ns/1ps
module tb_color_sensor_target;
    localparam int Q = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_drv_low = 1'b0;
    wire         sda;
    logic [15:0] red = '0, green = '0, blue = '0;
    logic        sample_valid = 1'b0;
    logic [7:0]  cfg1, cfg2, cfg3;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    int          low_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    pullup (sda);
    assign sda = sda_drv_low ? 1'b0 : 1'bz;

    color_sensor_target dut (
        .clock_i(clk), .reset_n_i(rst_n), .scl_i(scl), .sda_io(sda),
        .red_i(red), .green_i(green), .blue_i(blue), .sample_valid_i(sample_valid),
        .config1_o(cfg1), .config2_o(cfg2), .config3_o(cfg3), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!sda_drv_low && sda === 1'b0) low_cnt <= low_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic wr_bit(input logic b);
        sda_drv_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic rd_bit(output logic b);
        sda_drv_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_start;
        sda_drv_low = 1'b0; #Q; scl = 1'b1; #Q; sda_drv_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop;
        sda_drv_low = 1'b1; #Q; scl = 1'b1; #Q; sda_drv_low = 1'b0; #(2*Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(b);
        acked = (b === 1'b0);
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin rd_bit(b); d[i] = b; end
        wr_bit(~ack);
        sda_drv_low = 1'b0;
    endtask

    // Writes n bytes (n <= 4) after an already issued START; returns the NACK count.
    task automatic wr_bytes(input int n, input logic [7:0] b0, b1, b2, b3, output int nacks);
        logic [7:0] bytes [4];
        logic       a;
        bytes = '{b0, b1, b2, b3};
        nacks = 0;
        for (int i = 0; i < n; i++) begin wr_byte(bytes[i], a); if (!a) nacks++; end
    endtask

    task automatic start_read_at(input logic [7:0] ptr, output int nacks);
        int n1, n2;
        i2c_start; wr_bytes(2, 8'h88, ptr, 8'h00, 8'h00, n1);
        i2c_start; wr_bytes(1, 8'h89, 8'h00, 8'h00, 8'h00, n2);
        nacks = n1 + n2;
    endtask

    task automatic rd_burst(input int n, input logic nack_last);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            rd_byte(!(nack_last && i == n - 1), d);
            got_q.push_back(d);
        end
    endtask

    task automatic pulse_sample(input logic [15:0] r, g, b);
        @(negedge clk); red = r; green = g; blue = b; sample_valid = 1'b1;
        @(negedge clk); sample_valid = 1'b0;
    endtask

    task automatic test_reset;
        #100;
        n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected 1", sda); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({cfg1, cfg2, cfg3} !== 24'h0) begin
            n_fail++; $display("FAIL reset_cfg: got %h %h %h expected 00 00 00", cfg1, cfg2, cfg3); end
        rst_n = 1'b1;
        #(4*Q);
    endtask

    task automatic test_write;
        int nk;
        logic [7:0] e, g;
        i2c_start; wr_bytes(3, 8'h88, 8'h03, 8'hC3, 8'h00, nk); i2c_stop;
        n_checks++; if (nk !== 0) begin n_fail++; $display("FAIL write_cfg3_acks: got %0d nacks expected 0", nk); end
        i2c_start; wr_bytes(4, 8'h88, 8'h01, 8'h0D, 8'h3F, nk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b expected 1", busy); end
        i2c_stop;
        n_checks++; if (nk !== 0) begin n_fail++; $display("FAIL write_acks: got %0d nacks expected 0", nk); end
        n_checks++; if ({cfg1, cfg2, cfg3} !== 24'h0D3FC3) begin
            n_fail++; $display("FAIL write_cfg: got %h %h %h expected 0d 3f c3", cfg1, cfg2, cfg3); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
        // A read with no pointer write lands on the post-increment pointer, 0x03.
        i2c_start; wr_bytes(1, 8'h89, 8'h00, 8'h00, 8'h00, nk);
        exp_q.push_back(8'hC3);
        rd_burst(1, 1'b1); i2c_stop;
        n_checks++; if (nk !== 0) begin n_fail++; $display("FAIL ptr_read_ack: got %0d nacks expected 0", nk); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL ptr_after_write: got %h expected %h", g, e); end
        end
        got_q.delete();
    endtask

    task automatic test_sample_read;
        int nk, l0, i;
        logic [7:0] e, g;
        pulse_sample(16'h1234, 16'h5678, 16'h9ABC);
        repeat (3) @(negedge clk);
        start_read_at(8'h09, nk);
        n_checks++; if (nk !== 0) begin n_fail++; $display("FAIL sample_read_acks: got %0d nacks expected 0", nk); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sample_read_busy: got %b expected 1", busy); end
        exp_q.push_back(8'h78); exp_q.push_back(8'h56); exp_q.push_back(8'h34);
        exp_q.push_back(8'h12); exp_q.push_back(8'hBC); exp_q.push_back(8'h9A);
        rd_burst(6, 1'b1);
        l0 = low_cnt;
        #(2*Q);
        n_checks++; if (sda !== 1'b1 || low_cnt !== l0) begin
            n_fail++; $display("FAIL sda_after_nack: got sda %b low_cycles %0d expected released", sda, low_cnt - l0); end
        i2c_stop;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL sample_read byte %0d: got %h expected %h", i, g, e); end
            i++;
        end
        got_q.delete();
    endtask

    task automatic test_sample_mid_read;
        int nk, i;
        logic [7:0] e, g;
        start_read_at(8'h09, nk);
        exp_q.push_back(8'h78); exp_q.push_back(8'h56); exp_q.push_back(8'h34);
        exp_q.push_back(8'h12); exp_q.push_back(8'hBC); exp_q.push_back(8'h9A);
        rd_burst(2, 1'b0);
        pulse_sample(16'hC0DE, 16'hBEEF, 16'hF00D);
        rd_burst(4, 1'b1);
        i2c_stop;
        repeat (5) @(negedge clk);
        start_read_at(8'h08, nk);
        exp_q.push_back(8'h01); exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
        exp_q.push_back(8'hDE); exp_q.push_back(8'hC0); exp_q.push_back(8'h0D);
        exp_q.push_back(8'hF0);
        rd_burst(7, 1'b1); i2c_stop;
        start_read_at(8'h08, nk);
        exp_q.push_back(8'h00);
        rd_burst(1, 1'b1); i2c_stop;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL mid_read byte %0d: got %h expected %h", i, g, e); end
            i++;
        end
        got_q.delete();
    endtask

    task automatic test_id_wrap;
        int nk, i;
        logic [7:0] e, g;
        start_read_at(8'h00, nk);
        exp_q.push_back(8'h7D);
        rd_burst(1, 1'b1); i2c_stop;
        start_read_at(8'h0F, nk);
        exp_q.push_back(8'h00); exp_q.push_back(8'h7D);
        rd_burst(2, 1'b1); i2c_stop;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL id_wrap byte %0d: got %h expected %h", i, g, e); end
            i++;
        end
        got_q.delete();
    endtask

    task automatic test_wrong_addr;
        int nk, l0;
        l0 = low_cnt;
        i2c_start; wr_bytes(1, 8'h8A, 8'h00, 8'h00, 8'h00, nk);
        n_checks++; if (nk !== 1) begin n_fail++; $display("FAIL wrong_addr_nack: got %0d nacks expected 1", nk); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_busy: got %b expected 0", busy); end
        wr_bytes(2, 8'h01, 8'hFF, 8'h00, 8'h00, nk);
        i2c_stop;
        n_checks++; if ({cfg1, cfg2, cfg3} !== 24'h0D3FC3) begin
            n_fail++; $display("FAIL wrong_addr_cfg: got %h %h %h expected 0d 3f c3", cfg1, cfg2, cfg3); end
        n_checks++; if (low_cnt !== l0) begin
            n_fail++; $display("FAIL wrong_addr_sda: got %0d driven-low cycles expected 0", low_cnt - l0); end
    endtask

    task automatic test_reset_mid_ack;
        int nk;
        logic found;
        logic [7:0] e, g;
        i2c_start; wr_bytes(3, 8'h88, 8'h03, 8'hA5, 8'h00, nk); i2c_stop;
        i2c_start;
        for (int i = 7; i >= 0; i--) wr_bit(logic'(8'h88 >> i));
        sda_drv_low = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin @(negedge clk); if (sda === 1'b0) found = 1'b1; end
        n_checks++; if (!found) begin n_fail++; $display("FAIL reset_ack_drive: got sda %b expected 0 before reset", sda); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_release: got sda %b expected 1", sda); end
        n_checks++; if ({cfg1, cfg2, cfg3, busy} !== 25'h0) begin
            n_fail++; $display("FAIL reset_mid_cfg: got %h %h %h busy %b expected 00 00 00 0", cfg1, cfg2, cfg3, busy); end
        #20; rst_n = 1'b1;
        #Q; scl = 1'b1; #(2*Q);
        i2c_start; wr_bytes(3, 8'h88, 8'h02, 8'h55, 8'h00, nk); i2c_stop;
        n_checks++; if (nk !== 0 || cfg2 !== 8'h55) begin
            n_fail++; $display("FAIL post_reset_write: got nacks %0d cfg2 %h expected 0 55", nk, cfg2); end
        start_read_at(8'h02, nk);
        exp_q.push_back(8'h55);
        rd_burst(1, 1'b1); i2c_stop;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL post_reset_read: got %h expected %h", g, e); end
        end
        got_q.delete();
    endtask

    initial begin
        test_reset;
        test_write;
        test_sample_read;
        test_sample_mid_read;
        test_id_wrap;
        test_wrong_addr;
        test_reset_mid_ack;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
